// File: rtl/matrix_proc_pkg.sv
// Shared definitions for the matrix processor host loader: FSM states,
// header word locations and the bytes-per-word helper.
package matrix_proc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR1,
    LOAD,
    WRITE,
    CHK,
    RUN,
    RD_HDR,
    DUMP_RD,
    DUMP_TX
  } loader_state_e;

  localparam int R_START_LOC = 5;
  localparam int R_END_LOC   = 8;

  function automatic int bytes_per_word(input int data_width);
    return (data_width + 7) / 8;
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Byte/word shift register shared by the load path (bytes in, LSB first)
// and the dump path (word in, bytes out LSB first), with a byte counter.
module byte_word_packer #(
  parameter int WORD_WIDTH     = 36,
  parameter int BYTES_PER_WORD = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_in_i,
  input  logic [7:0]            byte_i,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic                  shift_out_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic [7:0]            byte_o,
  output logic                  last_o
);

  localparam int SR_WIDTH  = BYTES_PER_WORD * 8;
  localparam int CNT_WIDTH = $clog2(BYTES_PER_WORD + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(BYTES_PER_WORD - 1);

  logic [SR_WIDTH-1:0]  sr_q, sr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           top_byte;

  // New bytes enter at the top so the first byte received ends up in bits [7:0].
  assign top_byte = shift_in_i ? byte_i : 8'h00;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = SR_WIDTH'(word_i);
      cnt_d = '0;
    end else if (shift_in_i || shift_out_i) begin
      sr_d  = SR_WIDTH'({top_byte, sr_q} >> 8);
      cnt_d = last_o ? '0 : cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o = sr_q[WORD_WIDTH-1:0];
  assign byte_o = sr_q[7:0];
  assign last_o = (cnt_q == LAST_IDX);

endmodule

// File: rtl/matrix_mem_loader.sv
// Host load/run/unload controller for the matrix processor data memory.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module matrix_mem_loader
  import matrix_proc_pkg::*;
#(
  parameter int REG_WIDTH           = 12,
  parameter int CORE_COUNT          = 3,
  parameter int DATA_MEM_ADDR_WIDTH = 12
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [7:0]                          rx_data,
  input  logic                                rx_valid,
  output logic                                rx_ready,
  output logic [7:0]                          tx_data,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic                                mem_sel,
  output logic [DATA_MEM_ADDR_WIDTH-1:0]      mem_addr,
  output logic                                mem_wr_en,
  output logic [REG_WIDTH*CORE_COUNT-1:0]     mem_wr_data,
  input  logic [REG_WIDTH*CORE_COUNT-1:0]     mem_rd_data,
  output logic                                proc_start,
  input  logic                                proc_done,
  output logic                                busy,
  output logic                                err
);

  localparam int DATA_MEM_WIDTH = REG_WIDTH * CORE_COUNT;
  localparam int BYTES_PER_WORD = bytes_per_word(DATA_MEM_WIDTH);
  localparam int AW             = DATA_MEM_ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  loader_state_e        state_q;
  logic [1:0]           phase_q;
  logic                 rx_ready_q;
  logic                 tx_valid_q;
  logic                 mem_sel_q;
  logic [AW-1:0]        mem_addr_q;
  logic                 mem_wr_en_q;
  logic                 proc_start_q;
  logic                 busy_q;
  logic                 err_q;
  logic [7:0]           hdr_lo_q;
  logic [7:0]           csum_q;
  logic [AW-1:0]        words_left_q;
  logic [REG_WIDTH-1:0] r_start_q;
  logic [REG_WIDTH-1:0] r_end_q;
  logic [REG_WIDTH-1:0] r_cur_q;

  logic                 rx_fire;
  logic                 tx_fire;
  logic [AW-1:0]        hdr_n;
  logic [REG_WIDTH-1:0] rd_reg;
  logic [REG_WIDTH-1:0] r_next;
  logic                 pk_shift_in;
  logic                 pk_load;
  logic                 pk_last;
  logic [7:0]           pk_byte;
  logic [DATA_MEM_WIDTH-1:0] pk_word;

  assign rx_fire     = rx_valid && rx_ready_q;
  assign tx_fire     = tx_valid_q && tx_ready;
  assign hdr_n       = AW'({rx_data, hdr_lo_q});
  assign rd_reg      = mem_rd_data[REG_WIDTH-1:0];
  assign r_next      = r_cur_q + REG_WIDTH'(1);
  assign pk_shift_in = rx_fire && (state_q == LOAD);
  assign pk_load     = (state_q == DUMP_RD) && (phase_q == 2'd1);

  byte_word_packer #(
    .WORD_WIDTH     (DATA_MEM_WIDTH),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .shift_in_i  (pk_shift_in),
    .byte_i      (rx_data),
    .load_i      (pk_load),
    .word_i      (mem_rd_data),
    .shift_out_i (tx_fire),
    .word_o      (pk_word),
    .byte_o      (pk_byte),
    .last_o      (pk_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      rx_ready_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      mem_sel_q    <= 1'b1;
      mem_addr_q   <= '0;
      mem_wr_en_q  <= 1'b0;
      proc_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      hdr_lo_q     <= '0;
      csum_q       <= '0;
      words_left_q <= '0;
      r_start_q    <= '0;
      r_end_q      <= '0;
      r_cur_q      <= '0;
    end else begin
      if (rx_fire) csum_q <= (state_q == IDLE) ? rx_data : (csum_q ^ rx_data);
      case (state_q)
        IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            hdr_lo_q   <= rx_data;
            mem_addr_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= HDR1;
          end
        end
        HDR1: begin
          if (rx_fire) begin
            words_left_q <= hdr_n;
            if (hdr_n != '0) begin
              state_q <= LOAD;
            end else if (CHK_EN) begin
              state_q <= CHK;
            end else begin
              rx_ready_q   <= 1'b0;
              proc_start_q <= 1'b1;
              mem_sel_q    <= 1'b0;
              state_q      <= RUN;
            end
          end
        end
        LOAD: begin
          if (rx_fire && pk_last) begin
            rx_ready_q  <= 1'b0;
            mem_wr_en_q <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          mem_wr_en_q  <= 1'b0;
          mem_addr_q   <= mem_addr_q + AW'(1);
          words_left_q <= words_left_q - AW'(1);
          if (words_left_q != AW'(1)) begin
            rx_ready_q <= 1'b1;
            state_q    <= LOAD;
          end else if (CHK_EN) begin
            rx_ready_q <= 1'b1;
            state_q    <= CHK;
          end else begin
            proc_start_q <= 1'b1;
            mem_sel_q    <= 1'b0;
            state_q      <= RUN;
          end
        end
        CHK: begin
          if (rx_fire) begin
            rx_ready_q <= 1'b0;
            if (rx_data == csum_q) begin
              proc_start_q <= 1'b1;
              mem_sel_q    <= 1'b0;
              state_q      <= RUN;
            end else begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        RUN: begin
          if (proc_done) begin
            proc_start_q <= 1'b0;
            mem_sel_q    <= 1'b1;
            mem_addr_q   <= AW'(R_START_LOC);
            phase_q      <= '0;
            state_q      <= RD_HDR;
          end
        end
        RD_HDR: begin
          // Phase 0 issues R_end's read; phases 1/2 capture R_start/R_end data.
          case (phase_q)
            2'd0: begin
              mem_addr_q <= AW'(R_END_LOC);
              phase_q    <= 2'd1;
            end
            2'd1: begin
              r_start_q <= rd_reg;
              phase_q   <= 2'd2;
            end
            default: begin
              r_end_q <= rd_reg;
              phase_q <= '0;
              if (rd_reg < r_start_q) begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                r_cur_q    <= r_start_q;
                mem_addr_q <= AW'(r_start_q);
                state_q    <= DUMP_RD;
              end
            end
          endcase
        end
        DUMP_RD: begin
          if (phase_q == 2'd0) begin
            phase_q <= 2'd1;
          end else begin
            phase_q    <= '0;
            tx_valid_q <= 1'b1;
            state_q    <= DUMP_TX;
          end
        end
        DUMP_TX: begin
          if (tx_fire && pk_last) begin
            tx_valid_q <= 1'b0;
            if (r_cur_q == r_end_q) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              r_cur_q    <= r_next;
              mem_addr_q <= AW'(r_next);
              state_q    <= DUMP_RD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_ready    = rx_ready_q;
  assign tx_data     = pk_byte;
  assign tx_valid    = tx_valid_q;
  assign mem_sel     = mem_sel_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_data = pk_word;
  assign proc_start  = proc_start_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_matrix_mem_loader.sv
// Scoreboard bench for matrix_mem_loader: directed streams, dump checks,
// backpressure, empty dump range, mid-word reset and optional checksum error.
module tb_matrix_mem_loader;

  localparam int DW = 36;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          proc_start;
  logic          proc_done;
  logic          busy;
  logic          err;

  logic          tb_wr_en;
  logic [AW-1:0] tb_wr_addr;
  logic [DW-1:0] tb_wr_data;
  logic          bp_mode;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  matrix_mem_loader #(
    .REG_WIDTH           (12),
    .CORE_COUNT          (3),
    .DATA_MEM_ADDR_WIDTH (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .mem_sel     (mem_sel),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .proc_start  (proc_start),
    .proc_done   (proc_done),
    .busy        (busy),
    .err         (err)
  );

  // Data memory model with registered read and a bench-side preload port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
    else if (mem_wr_en && mem_sel) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples 2ns after the falling edge, after stimulus has settled.
  initial begin
    logic [7:0] held;
    logic       hold_pend;
    wr_t        w;
    logic [7:0] b;
    hold_pend = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (mem_wr_en) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_write: addr %h data %h, expected no write", mem_addr, mem_wr_data);
        end else begin
          w = wr_q.pop_front();
          check("mem_write", {mem_sel, mem_addr, mem_wr_data}, {1'b1, w.addr, w.data});
        end
      end
      if (hold_pend) check("tx_hold", {tx_valid, tx_data}, {1'b1, held});
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_tx: byte %h, expected no byte", tx_data);
        end else begin
          b = tx_q.pop_front();
          check("tx_byte", tx_data, b);
          $display("tx byte %h", tx_data);
        end
      end
      hold_pend = tx_valid && !tx_ready;
      held = tx_data;
    end
  end

  // Transmitter ready: always ready, or 1 cycle in 3 under backpressure.
  initial begin
    int cyc;
    cyc = 0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      tx_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1);
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_wr_addr = a;
    tb_wr_data = d;
    tb_wr_en = 1'b1;
    @(negedge clk);
    tb_wr_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) check("rx_ready_timeout", rx_ready, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    $display("rx byte %h", b);
  endtask

  task automatic send_stream(input int nw, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic bad_chk);
    logic [7:0]  x;
    logic [39:0] v;
    logic [15:0] n;
    n = 16'(nw);
    x = n[7:0] ^ n[15:8];
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < nw; i++) begin
      v = (i == 0) ? 40'(w0) : 40'(w1);
      wr_q.push_back('{addr: AW'(i), data: v[DW-1:0]});
      for (int k = 0; k < 5; k++) begin
        x ^= v[k*8 +: 8];
        send_byte(v[k*8 +: 8]);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_chk ? ~x : x);
`else
    if (bad_chk) $display("note: checksum byte not used in this build");
`endif
  endtask

  task automatic load_and_start(input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    send_stream(2, w0, w1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    check("start_after_chk", {proc_start, mem_sel}, 2'b10);
`else
    check("start_low_in_write", {mem_wr_en, proc_start}, 2'b10);
    @(negedge clk);
    check("start_rise", {proc_start, mem_sel}, 2'b10);
`endif
  endtask

  task automatic pulse_done();
    repeat (2) @(negedge clk);
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
    check("start_fall", {proc_start, mem_sel}, 2'b01);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (busy && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic push_dump_bytes();
    logic [7:0] exp_b [10];
    exp_b = '{8'h33, 8'h23, 8'h22, 8'h11, 8'h01, 8'h66, 8'h56, 8'h55, 8'h44, 8'h04};
    for (int i = 0; i < 10; i++) tx_q.push_back(exp_b[i]);
  endtask

  task automatic check_reset(input string name);
    check(name, {rx_ready, tx_valid, tx_data, mem_sel, mem_addr, mem_wr_en, mem_wr_data,
                 proc_start, busy, err},
          {1'b0, 1'b0, 8'h00, 1'b1, 12'h000, 1'b0, 36'h0, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    proc_done = 1'b0;
    bp_mode = 1'b0;
    tb_wr_en = 1'b0;
    tb_wr_addr = '0;
    tb_wr_data = '0;
    repeat (3) @(negedge clk);
    check_reset("reset_values");
    poke(12'h005, 36'h00000000A);
    poke(12'h008, 36'h00000000B);
    poke(12'h00A, 36'h111222333);
    poke(12'h00B, 36'h444555666);
    rst = 1'b0;

    // proc_done outside RUN is ignored
    @(negedge clk);
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
    @(negedge clk);
    check("done_in_idle", busy, 1'b0);

    // Two-word load then dump of R words 0x00A..0x00B, no backpressure
    load_and_start(36'h123456789, 36'hABCDEF012);
    push_dump_bytes();
    pulse_done();
    wait_idle("dump_idle");
    check("dump_drained", 32'(tx_q.size()), 32'd0);

    // Same dump with the transmitter ready one cycle in three
    load_and_start(36'h123456789, 36'hABCDEF012);
    push_dump_bytes();
    bp_mode = 1'b1;
    pulse_done();
    wait_idle("bp_dump_idle");
    bp_mode = 1'b0;
    check("bp_dump_drained", 32'(tx_q.size()), 32'd0);

    // R_end < R_start: no dump, busy falls 3 cycles after proc_done
    poke(12'h005, 36'h000000007);
    poke(12'h008, 36'h000000003);
    load_and_start(36'h000000001, 36'hFFFFFFFFF);
    repeat (2) @(negedge clk);
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
    repeat (2) @(negedge clk);
    check("skip_busy_hold", busy, 1'b1);
    @(negedge clk);
    check("skip_busy_fall", busy, 1'b0);

    // N = 0: straight to RUN
    send_stream(0, '0, '0, 1'b0);
    check("n0_start", {proc_start, mem_sel}, 2'b10);
    pulse_done();
    wait_idle("n0_idle");

    // Reset while the third byte of word 0 is presented
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h89);
    send_byte(8'h67);
    rx_data = 8'h45;
    rx_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check_reset("rst_midword");
    rst = 1'b0;
    load_and_start(36'h0F0F0F0F0, 36'h5A5A5A5A5);

    // Reset during RUN drops proc_start on the next cycle
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_in_run");
    rst = 1'b0;

`ifdef LOADER_CHECKSUM_EN
    send_stream(1, 36'h123456789, '0, 1'b1);
    check("chk_err", {err, busy}, 2'b10);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (proc_start) seen++;
    end
    check("chk_no_start", 32'(seen), 32'd0);
`else
    seen = 0;
    check("err_tied", {err, 31'(seen)}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("writes_drained", 32'(wr_q.size()), 32'd0);
    check("tx_all_drained", 32'(tx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
